// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with BOOT/RUN/HANDLER control and fault detection.
// Define PC_SEQUENCER_PERF_EN to add the stall_cnt / redirect_cnt performance counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] br_target,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        intreq,
  output logic [31:0] pc,
  output logic [31:0] pc8,
  output logic [11:0] imem_addr,
  output logic        fetch_valid,
  output logic        fetch_fault,
  output logic        in_handler
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_HANDLER = 2'd2
  } state_t;

  // 33-bit end address so a memory ending at 2^32 does not wrap to zero.
  localparam logic [32:0] IMEM_END = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        w_fault;
  logic        w_int_take;

  assign w_fault    = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || ({1'b0, r_pc} >= IMEM_END);
  assign w_int_take = (r_state == S_RUN) && intreq;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN, S_HANDLER: begin
        if (w_int_take) begin
          w_pc_nxt    = HANDLER_PC;
          w_state_nxt = S_HANDLER;
        end else if (!stall) begin
          if (eret) begin
            w_pc_nxt    = epc;
            w_state_nxt = S_RUN;
          end else if (branch) begin
            w_pc_nxt = br_target;
          end else if (!w_fault) begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign pc          = r_pc;
  assign pc8         = r_pc + 32'd8;
  assign imem_addr   = 12'((r_pc - RESET_PC) >> 2);
  assign fetch_fault = w_fault;
  assign fetch_valid = (r_state != S_BOOT) && !w_fault;
  assign in_handler  = (r_state == S_HANDLER);

`ifdef PC_SEQUENCER_PERF_EN
  logic        w_active;
  logic        w_redirect;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redirect_cnt;

  assign w_active   = (r_state == S_RUN) || (r_state == S_HANDLER);
  assign w_redirect = w_int_take || (w_active && !stall && (eret || branch));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_active && stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect)        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the fetch-address rules.
module tb_pc_sequencer;

  localparam longint RST_PC  = 64'h3000;
  localparam longint HND_PC  = 64'h4180;
  localparam longint WORDS   = 4096;
  localparam longint TWO32   = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        stall, branch, eret, intreq;
  logic [31:0] br_target, epc;
  logic [31:0] pc, pc8;
  logic [11:0] imem_addr;
  logic        fetch_valid, fetch_fault, in_handler;
`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] stall_cnt, redirect_cnt;
`endif

  pc_sequencer dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .stall       (stall),
    .branch      (branch),
    .br_target   (br_target),
    .eret        (eret),
    .epc         (epc),
    .intreq      (intreq),
    .pc          (pc),
    .pc8         (pc8),
    .imem_addr   (imem_addr),
    .fetch_valid (fetch_valid),
    .fetch_fault (fetch_fault),
    .in_handler  (in_handler)
`ifdef PC_SEQUENCER_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 = BOOT, 1 = RUN, 2 = HANDLER
  int          m_mode;
  longint      m_pc;
  logic [31:0] m_stall_cnt, m_redir_cnt;

  function automatic bit exp_fault(longint p);
    return (p % 4 != 0) || (p < RST_PC) || (p >= RST_PC + 4 * WORDS);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc = RST_PC;
    m_stall_cnt = 0;
    m_redir_cnt = 0;
  endtask

  task automatic model_edge();
    bit took_int;
    if (m_mode == 0) begin
      m_mode = 1;
    end else begin
      took_int = (m_mode == 1) && intreq;
      if (stall) m_stall_cnt = m_stall_cnt + 1;
      if (took_int || (!stall && (eret || branch))) m_redir_cnt = m_redir_cnt + 1;
      if (took_int) begin
        m_pc = HND_PC;
        m_mode = 2;
      end else if (!stall) begin
        if (eret) begin
          m_pc = longint'({32'b0, epc});
          m_mode = 1;
        end else if (branch) begin
          m_pc = longint'({32'b0, br_target});
        end else if (!exp_fault(m_pc)) begin
          m_pc = (m_pc + 4) % TWO32;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    longint pc8_l, idx_l;
    bit     f;
    pc8_l = (m_pc + 8) % TWO32;
    idx_l = ((m_pc - RST_PC + TWO32) % TWO32) / 4 % 4096;
    f     = exp_fault(m_pc);
    chk({tag, ".pc"}, pc, m_pc[31:0]);
    chk({tag, ".pc8"}, pc8, pc8_l[31:0]);
    chk({tag, ".imem"}, {20'b0, imem_addr}, idx_l[31:0]);
    chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, f});
    chk({tag, ".valid"}, {31'b0, fetch_valid}, {31'b0, (m_mode != 0) && !f});
    chk({tag, ".inh"}, {31'b0, in_handler}, {31'b0, m_mode == 2});
`ifdef PC_SEQUENCER_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall_cnt);
    chk({tag, ".redir_cnt"}, redirect_cnt, m_redir_cnt);
`endif
  endtask

  task automatic idle();
    stall = 0; branch = 0; eret = 0; intreq = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    clr_n = 1'b0;
    idle();
    br_target = 32'h0;
    epc = 32'h0;
    model_reset();

    // Reset state, then BOOT for one cycle and sequential fetch
    #12;
    check_all("reset");
    clr_n = 1'b1;
    #1;
    check_all("boot");
    step("run0");
    chk("run0.lit", pc, 32'h3000);
    step("run1");
    chk("run1.lit", pc, 32'h3004);
    step("run2");
    chk("run2.lit", pc, 32'h3008);
    chk("run2.imem", {20'b0, imem_addr}, 32'd2);
    step("run3");
    step("run4");
    chk("at3010", pc, 32'h3010);

    // Stalled branch is dropped
    stall = 1; branch = 1; br_target = 32'h3100;
    step("stall_br");
    chk("stall_br.lit", pc, 32'h3010);
    stall = 0; branch = 0;
    step("unstall");
    chk("unstall.lit", pc, 32'h3014);
    step("r5"); step("r6"); step("r7");
    chk("at3020", pc, 32'h3020);

    // Interrupt beats stall; no nesting; eret returns
    intreq = 1; stall = 1;
    step("int");
    chk("int.lit", pc, 32'h4180);
    chk("int.inh", {31'b0, in_handler}, 32'd1);
    stall = 0;
    step("int_nest");
    chk("int_nest.lit", pc, 32'h4184);
    intreq = 0; eret = 1; epc = 32'h3024;
    step("eret");
    chk("eret.lit", pc, 32'h3024);
    chk("eret.inh", {31'b0, in_handler}, 32'd0);

    // eret outranks branch
    eret = 1; branch = 1; br_target = 32'h3200; epc = 32'h3300;
    step("eret_br");
    chk("eret_br.lit", pc, 32'h3300);

    // Faulting fetch addresses hold pc; interrupt clears
    eret = 0; branch = 1; br_target = 32'h3002;
    step("mis");
    chk("mis.fault", {31'b0, fetch_fault}, 32'd1);
    branch = 0;
    step("mis_hold");
    chk("mis_hold.lit", pc, 32'h3002);
    branch = 1; br_target = 32'h7000;
    step("oor");
    chk("oor.fault", {31'b0, fetch_fault}, 32'd1);
    branch = 0;
    step("oor_hold");
    intreq = 1;
    step("oor_int");
    chk("oor_int.lit", pc, 32'h4180);
    chk("oor_int.fault", {31'b0, fetch_fault}, 32'd0);
    intreq = 0; eret = 1; epc = 32'h3000;
    step("back");

    // Top of address space: pc8 wraps modulo 2^32
    eret = 0; branch = 1; br_target = 32'hFFFF_FFFC;
    step("top");
    chk("top.pc8", pc8, 32'h0000_0004);
    branch = 0;
    step("top_hold");
    eret = 1; epc = 32'h3000;
    step("top_back");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 99) < 25);
      branch = ($urandom_range(0, 99) < 20);
      eret   = ($urandom_range(0, 99) < 10);
      intreq = ($urandom_range(0, 99) < 8);
      br_target = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095);
      epc       = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095);
      step("rand");
    end

    // Reset asserted mid-handler, between clock edges
    idle();
    eret = 1; epc = 32'h3040;
    step("pre_h");
    eret = 0; intreq = 1;
    step("enter_h");
    intreq = 0;
    step("in_h");
    chk("in_h.inh", {31'b0, in_handler}, 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst.lit", pc, 32'h3000);
    #3;
    clr_n = 1'b1;
    step("rerun0");
    step("rerun1");
    chk("rerun1.lit", pc, 32'h3004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
